vga_output_stage: RTL and testbench
===================================

# vga_output_stage

Downstream consumer of the colour generator: takes its 4-bit red/green/blue levels and drives the VGA connector. Generates 640x480@60 raster timing from the system clock via a pixel-rate clock enable. Outputs active-low sync pulses and blanks colour outside the visible area. Exposes pixel coordinates and a frame-start pulse so game logic can align to the raster.

## Interface
- CLK_DIV, 2, system clocks per pixel (50 MHz clk -> 25 MHz pixel rate); legal 1..16
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch, pixels
- H_SYNC, 96, horizontal sync width, pixels
- H_BP, 48, horizontal back porch, pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch, lines
- V_SYNC, 2, vertical sync width, lines
- V_BP, 33, vertical back porch, lines

Ports:
- clk  in  1  system clock; every flop in the block is clocked on its rising edge
- reset  in  1  synchronous, active-high reset
- red_in  in  4  colour level from the upstream stage
- green_in  in  4  colour level from the upstream stage
- blue_in  in  4  colour level from the upstream stage
- vga_r  out  4  red to the DAC; 0 while blanked
- vga_g  out  4  green to the DAC; 0 while blanked
- vga_b  out  4  blue to the DAC; 0 while blanked
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- x  out  10  current horizontal count (hcount)
- y  out  10  current vertical count (vcount)
- active  out  1  high while hcount < H_ACTIVE and vcount < V_ACTIVE
- frame_start  out  1  one-clk pulse when the raster returns to (0,0)

## Operation
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP, default 800
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP, default 525
- Pixel divider:
  - div counts 0..CLK_DIV-1, then wraps to 0.
  - tick = (div == CLK_DIV-1).
  - With CLK_DIV=1, tick is high every cycle.
- Horizontal counter:
  - On tick, hcount increments.
  - At H_TOTAL-1, hcount wraps to 0 and vcount increments.
- Vertical counter:
  - vcount wraps to 0 from V_TOTAL-1 on the same tick that hcount wraps.
  - All counters are unsigned and 10 bits wide.
- x, y and active are combinational from the current counters.
- hsync_next = !(hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]); default range is 656..751.
- vsync_next = !(vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]); default range is 490..491.
- Registered pin outputs, updated every clk (not only on tick):
  - vga_r/g/b <= active ? {red,green,blue}_in : 0
  - hsync <= hsync_next
  - vsync <= vsync_next
- frame_start <= tick && hcount==H_TOTAL-1 && vcount==V_TOTAL-1.
- Colour inputs are sampled every clk. An upstream change mid-pixel appears on the pins one clk later; there is no per-pixel hold.

## Timing
- Reset values:
  - div=0, hcount=0, vcount=0
  - vga_r/g/b=0, hsync=1, vsync=1, frame_start=0
  - x=0, y=0, active=1 (combinational from the reset counters)
- Reset asserted mid-frame: on the next edge, all state returns to the reset values. The raster restarts at (0,0) with no partial-line recovery.
- Latency:
  - Pin outputs lag x/y/active by exactly 1 clk.
  - frame_start is high in the same clk in which the counters first read (0,0).
- Line period is H_TOTAL*CLK_DIV clks; frame period is H_TOTAL*V_TOTAL*CLK_DIV clks (default 840000).
- Wrap: tick at (799,524) moves the counters to (0,0). No other transition skips or holds a count.

## Structure
- Package vga_pkg holds:
  - default timing constants
  - the H_TOTAL/V_TOTAL derivation as functions of the parameters
  - the coordinate width (10)
- Sub-module pixel_tick_gen (parameter CLK_DIV; ports clk, reset, tick) holds the divider.
- The counters, sync decode and output registers live in vga_output_stage.

## Test plan
- Reset for 3 clks, then release:
  - pins at reset values
  - tick on clk 2, 4, 6, ...
  - hcount reaches 1 on the first tick
- Count one line with default parameters:
  - hsync pin low for exactly 192 clks
  - hsync first low 1 clk after hcount becomes 656
  - line period 1600 clks
- Count a full frame:
  - vsync low for 2 lines (3200 clks)
  - frame_start pulses every 840000 clks
  - frame_start pulses exactly once per frame
- Hold colour inputs at 4'hF:
  - pins show F only while the delayed active is high
  - pins show 0 at hcount 640..799 and vcount 480..524
- Assert reset at (300,200) for 1 clk:
  - next clk has counters (0,0), hsync=vsync=1, colour 0
  - timing then resumes normally
- CLK_DIV=1 build:
  - tick every clk
  - line period 800 clks
  - hsync low 96 clks

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, coordinate type and the line/frame total helpers
// used by the output stage.
package vga_pkg;

    localparam int COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

    localparam int DEF_CLK_DIV  = 2;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_output_stage_pixel_tick_gen.sv
// Pixel-rate clock enable: one-cycle tick every CLK_DIV system clocks.
module pixel_tick_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div;

    // With CLK_DIV=1 the divider is pinned at zero, so tick stays high.
    assign tick = (div == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            div <= '0;
        end else if (tick) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

endmodule

// File: rtl/vga_output_stage.sv
// VGA raster timing and pin drive: counters advance on the pixel tick, while the
// colour/sync pin registers update every system clock one clk behind the counters.
module vga_output_stage
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         red_in,
    input  logic [3:0]         green_in,
    input  logic [3:0]         blue_in,
    output logic [3:0]         vga_r,
    output logic [3:0]         vga_g,
    output logic [3:0]         vga_b,
    output logic               hsync,
    output logic               vsync,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               active,
    output logic               frame_start
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam coord_t H_LAST     = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST     = coord_t'(V_TOTAL - 1);
    localparam coord_t H_VIS      = coord_t'(H_ACTIVE);
    localparam coord_t V_VIS      = coord_t'(V_ACTIVE);
    localparam coord_t HS_FIRST   = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t HS_LAST    = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam coord_t VS_FIRST   = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t VS_LAST    = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic   tick;
    coord_t hcount;
    coord_t vcount;
    logic   hsync_next;
    logic   vsync_next;
    logic   at_frame_end;

    pixel_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            hcount <= '0;
            vcount <= '0;
        end else if (tick) begin
            if (hcount == H_LAST) begin
                hcount <= '0;
                vcount <= (vcount == V_LAST) ? '0 : vcount + 1'b1;
            end else begin
                hcount <= hcount + 1'b1;
            end
        end
    end

    assign x            = hcount;
    assign y            = vcount;
    assign active       = (hcount < H_VIS) && (vcount < V_VIS);
    assign hsync_next   = !((hcount >= HS_FIRST) && (hcount <= HS_LAST));
    assign vsync_next   = !((vcount >= VS_FIRST) && (vcount <= VS_LAST));
    assign at_frame_end = tick && (hcount == H_LAST) && (vcount == V_LAST);

    // Pins sample the current counters every clk, so they trail x/y/active by one clk.
    always_ff @(posedge clk) begin
        if (reset) begin
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            vga_r       <= active ? red_in   : 4'h0;
            vga_g       <= active ? green_in : 4'h0;
            vga_b       <= active ? blue_in  : 4'h0;
            hsync       <= hsync_next;
            vsync       <= vsync_next;
            frame_start <= at_frame_end;
        end
    end

endmodule

// File: tb/tb_vga_output_stage.sv
// Bench for vga_output_stage: default, CLK_DIV=1 and a shrunken raster instance,
// with a cycle scoreboard on the shrunken one and directed timing measurements.
module tb_vga_output_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Default-timing instance
    logic       rst_a;
    logic [3:0] def_rin, def_gin, def_bin;
    logic [3:0] def_r, def_g, def_b;
    logic       def_hsync, def_vsync, def_active, def_fs;
    logic [9:0] def_x, def_y;

    vga_output_stage dut_def (
        .clk (clk), .reset (rst_a),
        .red_in (def_rin), .green_in (def_gin), .blue_in (def_bin),
        .vga_r (def_r), .vga_g (def_g), .vga_b (def_b),
        .hsync (def_hsync), .vsync (def_vsync),
        .x (def_x), .y (def_y), .active (def_active), .frame_start (def_fs)
    );

    // CLK_DIV=1 instance, default raster
    logic       rst_c;
    logic [3:0] fst_r, fst_g, fst_b;
    logic       fst_hsync, fst_vsync, fst_active, fst_fs;
    logic [9:0] fst_x, fst_y;

    vga_output_stage #(.CLK_DIV (1)) dut_fast (
        .clk (clk), .reset (rst_c),
        .red_in (def_rin), .green_in (def_gin), .blue_in (def_bin),
        .vga_r (fst_r), .vga_g (fst_g), .vga_b (fst_b),
        .hsync (fst_hsync), .vsync (fst_vsync),
        .x (fst_x), .y (fst_y), .active (fst_active), .frame_start (fst_fs)
    );

    // Shrunken raster: H 8+2+3+3=16, V 6+1+2+1=10, CLK_DIV=2 -> frame 320 clks
    logic       rst_b;
    logic [3:0] sm_rin, sm_gin, sm_bin;
    logic [3:0] sm_r, sm_g, sm_b;
    logic       sm_hsync, sm_vsync, sm_active, sm_fs;
    logic [9:0] sm_x, sm_y;

    vga_output_stage #(
        .CLK_DIV (2),
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_ACTIVE (6), .V_FP (1), .V_SYNC (2), .V_BP (1)
    ) dut_small (
        .clk (clk), .reset (rst_b),
        .red_in (sm_rin), .green_in (sm_gin), .blue_in (sm_bin),
        .vga_r (sm_r), .vga_g (sm_g), .vga_b (sm_b),
        .hsync (sm_hsync), .vsync (sm_vsync),
        .x (sm_x), .y (sm_y), .active (sm_active), .frame_start (sm_fs)
    );

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       act;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
        logic       hs;
        logic       vs;
        logic       fs;
    } sb_t;

    sb_t sb_q[$];
    logic sb_on = 1'b1;
    int md = 0, mh = 0, mv = 0;

    task automatic check_output(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cyc %0d)", name, actual, expected, cyc);
        end
    endtask

    // Reference raster for the shrunken instance; pushes the state expected after each edge.
    always @(posedge clk) begin : model
        sb_t  e;
        logic tk;
        if (rst_b) begin
            md = 0; mh = 0; mv = 0;
            e.r = 4'h0; e.g = 4'h0; e.b = 4'h0;
            e.hs = 1'b1; e.vs = 1'b1; e.fs = 1'b0;
        end else begin
            tk   = (md == 1);
            e.r  = ((mh < 8) && (mv < 6)) ? sm_rin : 4'h0;
            e.g  = ((mh < 8) && (mv < 6)) ? sm_gin : 4'h0;
            e.b  = ((mh < 8) && (mv < 6)) ? sm_bin : 4'h0;
            e.hs = !((mh >= 10) && (mh <= 12));
            e.vs = !((mv >= 7) && (mv <= 8));
            e.fs = tk && (mh == 15) && (mv == 9);
            md   = tk ? 0 : md + 1;
            if (tk) begin
                if (mh == 15) begin
                    mh = 0;
                    mv = (mv == 9) ? 0 : mv + 1;
                end else begin
                    mh = mh + 1;
                end
            end
        end
        e.x   = 10'(mh);
        e.y   = 10'(mv);
        e.act = (mh < 8) && (mv < 6);
        sb_q.push_back(e);
    end

    always @(negedge clk) begin : monitor
        sb_t got, want;
        if (sb_q.size() > 0) begin
            want = sb_q.pop_front();
            got  = {sm_x, sm_y, sm_active, sm_r, sm_g, sm_b, sm_hsync, sm_vsync, sm_fs};
            if (sb_on) begin
                n_checks++;
                if (got !== want) begin
                    n_fail++;
                    $display("[TB] FAIL small_raster: got %h, expected %h (cyc %0d)", got, want, cyc);
                end
            end
        end
    end

    // Colour changes every clk on the shrunken instance to expose any per-pixel hold.
    initial begin : colour_drive
        logic [3:0] sc;
        sc = 4'h0;
        sm_rin = 4'h0; sm_gin = 4'h0; sm_bin = 4'h0;
        forever begin
            @(negedge clk);
            sc = sc + 4'd3;
            sm_rin = sc;
            sm_gin = ~sc;
            sm_bin = sc ^ 4'h5;
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic apply_stimulus(input logic a, input logic b, input logic c);
        rst_a = a;
        rst_b = b;
        rst_c = c;
    endtask

    task automatic measure_default();
        int t656, tfall1, tfall2, width, guard, hits, blanks;
        t656 = -1; guard = 0;
        do begin
            @(negedge clk); guard++;
            if (def_x == 10'd656 && t656 < 0) t656 = cyc;
        end while (def_hsync !== 1'b0 && guard < 4000);
        tfall1 = cyc;
        check_output("def_hsync_after_656", tfall1 - t656, 1);
        width = 0;
        do begin @(negedge clk); width++; end while (def_hsync === 1'b0 && width < 400);
        check_output("def_hsync_low_clks", width, 192);
        guard = 0;
        do begin @(negedge clk); guard++; end while (def_hsync !== 1'b0 && guard < 4000);
        tfall2 = cyc;
        check_output("def_line_period", tfall2 - tfall1, 1600);
        hits = 0; blanks = 0;
        for (int i = 0; i < 1600; i++) begin
            if (def_r == 4'hF && def_g == 4'hA && def_b == 4'h5) hits++;
            if (def_r == 4'h0 && def_g == 4'h0 && def_b == 4'h0) blanks++;
            @(negedge clk);
        end
        check_output("def_colour_visible_clks", hits, 1280);
        check_output("def_colour_blank_clks", blanks, 320);
    endtask

    task automatic measure_fast();
        int tfall1, width, guard;
        guard = 0;
        do begin @(negedge clk); guard++; end while (fst_hsync !== 1'b0 && guard < 2000);
        tfall1 = cyc;
        width = 0;
        do begin @(negedge clk); width++; end while (fst_hsync === 1'b0 && width < 200);
        check_output("fast_hsync_low_clks", width, 96);
        guard = 0;
        do begin @(negedge clk); guard++; end while (fst_hsync !== 1'b0 && guard < 2000);
        check_output("fast_line_period", cyc - tfall1, 800);
    endtask

    task automatic measure_small();
        int t1, pulses, width, guard;
        guard = 0;
        do begin @(negedge clk); guard++; end while (sm_fs !== 1'b1 && guard < 800);
        t1 = cyc;
        guard = 0;
        do begin @(negedge clk); guard++; end while (sm_fs !== 1'b1 && guard < 800);
        check_output("small_frame_period", cyc - t1, 320);
        pulses = 0;
        for (int i = 0; i < 640; i++) begin
            @(negedge clk);
            if (sm_fs === 1'b1) pulses++;
        end
        check_output("small_fs_per_two_frames", pulses, 2);
        guard = 0;
        do begin @(negedge clk); guard++; end while (sm_vsync !== 1'b0 && guard < 800);
        width = 0;
        do begin @(negedge clk); width++; end while (sm_vsync === 1'b0 && width < 200);
        check_output("small_vsync_low_clks", width, 64);
    endtask

    // Pulse the shrunken instance's reset at a chosen raster position.
    task automatic reset_at(input int px, input int py);
        int guard, cnt;
        guard = 0;
        do begin @(negedge clk); guard++; end
            while (!(sm_x == 10'(px) && sm_y == 10'(py)) && guard < 800);
        check_output("small_reach_reset_point", guard < 800 ? 1 : 0, 1);
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        check_output("small_rst_xy", {sm_x, sm_y}, 0);
        check_output("small_rst_sync", {sm_hsync, sm_vsync}, 3);
        check_output("small_rst_colour", {sm_r, sm_g, sm_b}, 0);
        check_output("small_rst_fs", sm_fs, 0);
        cnt = 0;
        do begin @(negedge clk); cnt++; end while (sm_fs !== 1'b1 && cnt < 400);
        check_output("small_restart_frame_clks", cnt, 320);
    endtask

    initial begin
        def_rin = 4'hF; def_gin = 4'hA; def_bin = 4'h5;
        apply_stimulus(1'b1, 1'b1, 1'b1);
        repeat (3) @(negedge clk);

        check_output("rst_def_colour", {def_r, def_g, def_b}, 0);
        check_output("rst_def_hsync", def_hsync, 1);
        check_output("rst_def_vsync", def_vsync, 1);
        check_output("rst_def_fs", def_fs, 0);
        check_output("rst_def_x", def_x, 0);
        check_output("rst_def_y", def_y, 0);
        check_output("rst_def_active", def_active, 1);
        check_output("rst_fast_x", fst_x, 0);

        apply_stimulus(1'b0, 1'b0, 1'b0);
        // Default divides by 2: x reads 0,1,1,2 over the first four clks; CLK_DIV=1 counts every clk.
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check_output($sformatf("tick_def_x_clk%0d", i), def_x, i / 2);
            check_output($sformatf("tick_fast_x_clk%0d", i), fst_x, i);
        end
        check_output("def_pins_after_release", {def_r, def_g, def_b}, 12'hFA5);

        fork
            measure_default();
            measure_fast();
            measure_small();
        join

        reset_at(5, 3);
        reset_at(11, 7);

        sb_on = 1'b0;
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
